// File: rtl/attempt_lockout_ctrl_pkg.sv
// Shared state encoding and default limits for the attempt lockout controller
// and anything that needs to agree with it (top level, benches).
package attempt_lockout_ctrl_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_READY     = 3'd0,
    S_UNLOCKED  = 3'd1,
    S_START_TMR = 3'd2,
    S_LOCKOUT   = 3'd3,
    S_ALARM     = 3'd4
  } state_t;

  localparam int unsigned DEF_CNT_W        = 2;
  localparam int unsigned DEF_MAX_ATTEMPTS = 3;
  localparam int unsigned DEF_MAX_LOCKOUTS = 2;
  localparam int unsigned LOCK_CNT_W       = 4;

endpackage

// File: rtl/attempt_lockout_ctrl.sv
// Wrong-code attempt counter with timed lockout (via interval_timer) and
// escalation to a permanent alarm after repeated lockouts.
module attempt_lockout_ctrl
  import attempt_lockout_ctrl_pkg::*;
#(
  parameter int unsigned MAX_ATTEMPTS = DEF_MAX_ATTEMPTS,
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned MAX_LOCKOUTS = DEF_MAX_LOCKOUTS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             code_valid,
  input  logic             code_match,
  input  logic             relock,
  input  logic             timer_done,
  output logic             timer_start,
  output logic             unlock,
  output logic             locked_out,
  output logic             alarm,
  output logic [CNT_W-1:0] fail_count
);

  localparam logic [CNT_W:0]        MAX_A_EXT = (CNT_W+1)'(MAX_ATTEMPTS);
  localparam logic [CNT_W-1:0]      MAX_A     = CNT_W'(MAX_ATTEMPTS);
  localparam logic [LOCK_CNT_W-1:0] MAX_L     = LOCK_CNT_W'(MAX_LOCKOUTS);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        fail_nxt;
  logic [LOCK_CNT_W-1:0]   lock_cnt, lock_nxt;
  logic [CNT_W:0]          fail_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_READY;
      fail_count <= '0;
      lock_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      fail_count <= fail_nxt;
      lock_cnt   <= lock_nxt;
    end
  end

  // Compared one bit wider so the limit test cannot wrap at the counter width.
  assign fail_inc = {1'b0, fail_count} + (CNT_W+1)'(1);

  always_comb begin
    state_nxt = state;
    fail_nxt  = fail_count;
    lock_nxt  = lock_cnt;
    unique case (state)
      S_READY: begin
        if (code_valid) begin
          if (code_match) begin
            state_nxt = S_UNLOCKED;
            fail_nxt  = '0;
          end else if (fail_inc < MAX_A_EXT) begin
            fail_nxt = fail_inc[CNT_W-1:0];
          end else begin
            fail_nxt  = MAX_A;
            state_nxt = (lock_cnt == MAX_L) ? S_ALARM : S_START_TMR;
          end
        end
      end
      S_UNLOCKED: begin
        if (relock) state_nxt = S_READY;
      end
      S_START_TMR: begin
        // timer_done deliberately not looked at here: a stale done from the
        // previous run must not end the new lockout.
        state_nxt = S_LOCKOUT;
        if (lock_cnt != '1) lock_nxt = lock_cnt + LOCK_CNT_W'(1);
      end
      S_LOCKOUT: begin
        if (timer_done) begin
          state_nxt = S_READY;
          fail_nxt  = '0;
        end
      end
      S_ALARM: begin
        state_nxt = S_ALARM;
      end
      default: begin
        state_nxt = S_READY;
      end
    endcase
  end

  assign timer_start = (state == S_START_TMR);
  assign unlock      = (state == S_UNLOCKED);
  assign locked_out  = (state == S_START_TMR) || (state == S_LOCKOUT);
  assign alarm       = (state == S_ALARM);

endmodule

// File: tb/tb_attempt_lockout_ctrl.sv
// Directed scenarios followed by random traffic, checked every cycle against
// an event-level model of the lockout rules.
module tb_attempt_lockout_ctrl;
  import attempt_lockout_ctrl_pkg::*;

  localparam int unsigned MAXA  = DEF_MAX_ATTEMPTS;
  localparam int unsigned MAXL  = DEF_MAX_LOCKOUTS;
  localparam int unsigned CW    = DEF_CNT_W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          code_valid = 1'b0;
  logic          code_match = 1'b0;
  logic          relock = 1'b0;
  logic          timer_done = 1'b0;
  logic          timer_start, unlock, locked_out, alarm;
  logic [CW-1:0] fail_count;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference model: what the safe "knows" at a higher level.
  int unsigned m_fails = 0;
  int unsigned m_lockouts = 0;
  bit          m_open = 0;
  bit          m_alarm = 0;
  bit          m_pulse = 0;
  bit          m_waiting = 0;
  bit          prev_start = 0;

  attempt_lockout_ctrl #(
    .MAX_ATTEMPTS(MAXA),
    .CNT_W(CW),
    .MAX_LOCKOUTS(MAXL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .code_valid(code_valid),
    .code_match(code_match),
    .relock(relock),
    .timer_done(timer_done),
    .timer_start(timer_start),
    .unlock(unlock),
    .locked_out(locked_out),
    .alarm(alarm),
    .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_fails = 0; m_lockouts = 0; m_open = 0; m_alarm = 0;
      m_pulse = 0; m_waiting = 0;
    end else if (m_alarm) begin
      // permanent until reset
    end else if (m_pulse) begin
      m_pulse = 0;
      m_waiting = 1;
      if (m_lockouts < 15) m_lockouts++;
    end else if (m_waiting) begin
      if (timer_done) begin
        m_waiting = 0;
        m_fails = 0;
      end
    end else if (m_open) begin
      if (relock) m_open = 0;
    end else if (code_valid) begin
      if (code_match) begin
        m_open = 1;
        m_fails = 0;
      end else if (m_fails + 1 < MAXA) begin
        m_fails++;
      end else begin
        m_fails = MAXA;
        if (m_lockouts == MAXL) m_alarm = 1;
        else m_pulse = 1;
      end
    end
  endtask

  task automatic step(input bit cv, input bit cm, input bit rl, input bit td, input bit r);
    @(negedge clk);
    code_valid = cv; code_match = cm; relock = rl; timer_done = td; rst = r;
    @(posedge clk);
    model_edge();
    #1;
    check_eq("unlock",      32'(unlock),      32'(m_open));
    check_eq("locked_out",  32'(locked_out),  32'(m_pulse | m_waiting));
    check_eq("alarm",       32'(alarm),       32'(m_alarm));
    check_eq("timer_start", 32'(timer_start), 32'(m_pulse));
    check_eq("fail_count",  32'(fail_count),  m_fails);
    check_eq("start_no_repeat", 32'(prev_start & timer_start), 0);
    prev_start = timer_start;
  endtask

  task automatic idle(input int unsigned n, input bit td);
    for (int unsigned i = 0; i < n; i++) step(0, 0, 0, td, 0);
  endtask

  task automatic wrong_code();
    step(1, 0, 0, 0, 0);
  endtask

  initial begin
    // reset and correct code
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0);
    idle(2, 0);
    step(1, 0, 0, 0, 0);            // ignored while unlocked
    step(0, 0, 1, 0, 0);
    // under-limit failures, then lockout #1
    wrong_code();
    wrong_code();
    wrong_code();                   // enters START_TMR
    step(1, 1, 0, 1, 0);            // done held across START_TMR; correct code ignored
    step(1, 1, 0, 0, 0);
    idle(8, 0);
    step(0, 0, 0, 1, 0);            // exits lockout
    idle(1, 0);
    // lockout #2
    for (int unsigned i = 0; i < MAXA; i++) wrong_code();
    idle(10, 0);
    step(0, 0, 1, 1, 0);
    // third limit hit escalates to alarm
    for (int unsigned i = 0; i < MAXA; i++) wrong_code();
    step(1, 1, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    idle(3, 1);
    step(0, 0, 0, 0, 1);
    idle(1, 0);
    // reset mid-lockout, stray done in READY, then unlock
    for (int unsigned i = 0; i < MAXA; i++) wrong_code();
    idle(3, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    // random traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 99) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/attempt_lockout_ctrl.md
Name: attempt_lockout_ctrl

Overview:
- Sits directly upstream of interval_timer and is the only driver of its start input; consumes its done output.
- Counts wrong-code attempts reported by the code-entry logic.
- On reaching the attempt limit, fires one timer start pulse and holds the safe in lockout until the timer reports done.
- Escalates to a permanent alarm after repeated lockouts; drives the unlock/locked_out/alarm status for the top-level controller.

Parameters:
- MAX_ATTEMPTS, 3, wrong codes that trigger a lockout; legal range 1..2^CNT_W-1.
- CNT_W, 2, width of the fail counter.
- MAX_LOCKOUTS, 2, completed lockouts after which the next limit hit enters ALARM; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- code_valid  in  1  one-cycle pulse: a full code entry is complete.
- code_match  in  1  qualifies code_valid: 1 = correct code; ignored when code_valid=0.
- relock  in  1  pulse: close the safe again from UNLOCKED.
- timer_done  in  1  done from interval_timer.
- timer_start  out  1  one-cycle start pulse to interval_timer.
- unlock  out  1  level; high while in UNLOCKED.
- locked_out  out  1  level; high in START_TMR and LOCKOUT.
- alarm  out  1  level; high in ALARM.
- fail_count  out  CNT_W  current wrong-attempt count.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- All outputs are registered (Moore outputs decoded from state or flopped).
- Reset, taking effect on the first rising edge with rst=1:
  - state=READY, fail_count=0, lockout counter=0.
  - timer_start=0, unlock=0, locked_out=0, alarm=0.
  - Reset mid-lockout drops locked_out at that edge. interval_timer is not reset by this block; any stray timer_done that arrives while in READY is ignored.
- States: READY, UNLOCKED, START_TMR, LOCKOUT, ALARM.
- READY:
  - code_valid & code_match -> UNLOCKED; fail_count cleared.
  - code_valid & ~code_match:
    - If fail_count+1 < MAX_ATTEMPTS: increment fail_count, stay in READY.
    - Otherwise, if lockout counter = MAX_LOCKOUTS: go to ALARM and set fail_count to MAX_ATTEMPTS.
    - Otherwise: go to START_TMR and set fail_count to MAX_ATTEMPTS.
  - Response appears one cycle after the code_valid edge.
- UNLOCKED:
  - unlock=1.
  - code_valid is ignored.
  - relock -> READY.
- START_TMR:
  - Lasts exactly one cycle; timer_start=1 only here.
  - Increment the lockout counter, saturating at 15.
  - Unconditionally -> LOCKOUT.
  - timer_done is ignored in this cycle, so a stale done from a previous run is not consumed.
- LOCKOUT:
  - code_valid and relock are ignored; fail_count holds.
  - First cycle with timer_done=1 -> READY; fail_count cleared.
  - timer_done may be a pulse or a level; only its presence in LOCKOUT matters.
  - No internal timeout: the block waits indefinitely.
- ALARM:
  - alarm=1, locked_out=0, unlock=0.
  - All inputs are ignored; only rst exits.
- Simultaneous events:
  - code_valid and relock in the same cycle in UNLOCKED: relock wins and code_valid is dropped.
  - rst overrides everything.
- fail_count never wraps, because the parameter range forbids MAX_ATTEMPTS > 2^CNT_W-1.
- timer_start is never high for two consecutive cycles.

Decomposition:
- Shared team params header holds:
  - State encoding localparams: S_READY=0, S_UNLOCKED=1, S_START_TMR=2, S_LOCKOUT=3, S_ALARM=4, with a 3-bit state width.
  - Default MAX_ATTEMPTS and MAX_LOCKOUTS, so the top level and benches share them.
- A single module with no sub-module is the intended structure. The fail and lockout counters are small enough to stay inline next to the FSM.

Test Plan:
- Correct code: rst 2 cycles, then code_valid=1,code_match=1 -> unlock=1 next cycle, fail_count=0; relock pulse -> unlock=0 next cycle.
- Under-limit failures: two wrong codes -> fail_count=1 then 2, locked_out=0, timer_start never asserted.
- Lockout entry: third wrong code -> next cycle locked_out=1 and timer_start=1 for exactly one cycle; code_valid with the correct code during LOCKOUT gives unlock=0.
- Lockout exit: drive timer_done high 10 cycles after timer_start -> READY next edge, locked_out=0, fail_count=0. Also check that timer_done=1 held during the START_TMR cycle does not exit lockout early.
- Alarm escalation, MAX_LOCKOUTS=2: complete two lockouts, then three more wrong codes -> alarm=1, timer_start stays 0; correct code and timer_done are ignored; rst -> alarm=0, fail_count=0.
- Reset mid-operation: rst asserted in LOCKOUT -> locked_out=0 at that edge. A later stray timer_done in READY changes nothing, and a correct code then unlocks.
